bin_bcd_converter: RTL and testbench



---
 rtl/bin_bcd_converter.sv | 100 ++++++++++
 tb/tb_bin_bcd_converter.sv | 177 +++++++++++++++++
 2 files changed

// File: rtl/bin_bcd_converter.sv
// Sequential binary-to-BCD converter (shift-and-add-3). One bit costs a CHECK and a SHIFT
// cycle, plus one LOAD cycle, so a result lands 2*BIN_WIDTH+1 edges after capture.
module bin_bcd_converter #(
  parameter int BIN_WIDTH = 10
) (
  input  logic                 CLK,
  input  logic                 RST,
  input  logic                 START,
  input  logic [BIN_WIDTH-1:0] BIN,
  output logic [15:0]          BCDOUT,
  output logic                 DONE,
  output logic                 BUSY
);

  localparam int CNT_W = (BIN_WIDTH < 2) ? 1 : $clog2(BIN_WIDTH + 1);
  localparam logic [CNT_W-1:0] LAST_BIT = CNT_W'(BIN_WIDTH - 1);

  typedef enum logic [1:0] {
    IDLE  = 2'd0,
    CHECK = 2'd1,
    SHIFT = 2'd2,
    LOAD  = 2'd3
  } state_t;

  state_t               state_reg;
  state_t               state_next;
  logic [BIN_WIDTH-1:0] bin_reg;
  logic [15:0]          scratch_reg;
  logic [15:0]          scratch_adj;
  logic [CNT_W-1:0]     cnt_reg;
  logic [15:0]          bcd_reg;
  logic                 done_reg;
  logic                 capture;
  logic                 load_en;

  always_ff @(posedge CLK or posedge RST) begin
    if (RST) begin
      state_reg <= IDLE;
    end else begin
      state_reg <= state_next;
    end
  end

  always_comb begin
    state_next = state_reg;
    case (state_reg)
      IDLE:    if (START) state_next = CHECK;
      CHECK:   state_next = SHIFT;
      SHIFT:   state_next = (cnt_reg == LAST_BIT) ? LOAD : CHECK;
      LOAD:    state_next = IDLE;
      default: state_next = IDLE;
    endcase
  end

  always_comb begin
    BUSY    = (state_reg != IDLE);
    capture = (state_reg == IDLE) && START;
    load_en = (state_reg == LOAD);
  end

  // Nibble-local +3 correction; no carry ever crosses a digit boundary.
  generate
    for (genvar gi = 0; gi < 4; gi++) begin : g_adj
      assign scratch_adj[gi*4 +: 4] = (scratch_reg[gi*4 +: 4] >= 4'd5)
                                    ? scratch_reg[gi*4 +: 4] + 4'd3
                                    : scratch_reg[gi*4 +: 4];
    end
  endgenerate

  always_ff @(posedge CLK or posedge RST) begin
    if (RST) begin
      bin_reg     <= '0;
      scratch_reg <= '0;
      cnt_reg     <= '0;
      bcd_reg     <= '0;
      done_reg    <= 1'b0;
    end else begin
      done_reg <= load_en;
      if (capture) begin
        bin_reg     <= BIN;
        scratch_reg <= '0;
        cnt_reg     <= '0;
      end
      if (state_reg == CHECK) begin
        scratch_reg <= scratch_adj;
      end
      if (state_reg == SHIFT) begin
        {scratch_reg, bin_reg} <= {scratch_reg[14:0], bin_reg, 1'b0};
        cnt_reg                <= cnt_reg + 1'b1;
      end
      if (load_en) begin
        bcd_reg <= scratch_reg;
      end
    end
  end

  assign BCDOUT = bcd_reg;
  assign DONE   = done_reg;

endmodule

// File: tb/tb_bin_bcd_converter.sv
// Directed bench for bin_bcd_converter: expected digits are queued at each capture and
// popped by a monitor whenever DONE is seen.
module tb_bin_bcd_converter;

  logic        clk;
  logic        rst;
  logic        start;
  logic [9:0]  bin;
  logic [15:0] bcdout;
  logic        done;
  logic        busy;

  int          n_total = 0;
  int          n_bad   = 0;
  int          done_cnt = 0;
  logic [15:0] exp_q[$];

  bin_bcd_converter #(.BIN_WIDTH(10)) dut (
    .CLK(clk), .RST(rst), .START(start), .BIN(bin),
    .BCDOUT(bcdout), .DONE(done), .BUSY(busy)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  function automatic logic [15:0] to_bcd(input int v);
    logic [3:0] d3, d2, d1, d0;
    d3 = 4'((v / 1000) % 10);
    d2 = 4'((v / 100) % 10);
    d1 = 4'((v / 10) % 10);
    d0 = 4'(v % 10);
    return {d3, d2, d1, d0};
  endfunction

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_total++;
    assert (obs === exp) else begin
      n_bad++;
      $error("FAIL %s observed=%h expected=%h", tag, obs, exp);
    end
  endtask

  task automatic edge_n(input int n);
    repeat (n) @(posedge clk);
    #1;
  endtask

  // Scoreboard monitor: every DONE pulse must match the oldest queued capture.
  always @(negedge clk) begin
    if (!rst && done) begin
      done_cnt++;
      if (exp_q.size() == 0) begin
        chk("done_without_capture", 32'(bcdout), 32'hFFFF_FFFF);
      end else begin
        logic [15:0] e;
        e = exp_q.pop_front();
        chk("scoreboard_bcd", 32'(bcdout), 32'(e));
        $display("result bcd=%h expected=%h", bcdout, e);
      end
    end
  end

  initial begin
    int d0;
    rst = 1'b1; start = 1'b0; bin = '0;
    repeat (2) @(posedge clk);
    #1 rst = 1'b0;
    chk("reset_bcdout", 32'(bcdout), 32'h0);
    chk("reset_done", 32'(done), 32'h0);
    chk("reset_busy", 32'(busy), 32'h0);

    // BIN=0, single request
    start = 1'b1; bin = 10'd0; exp_q.push_back(to_bcd(0));
    edge_n(1);
    chk("zero_busy_after_capture", 32'(busy), 32'h1);
    start = 1'b0;
    edge_n(20);
    chk("zero_done_e20", 32'(done), 32'h0);
    chk("zero_busy_e20", 32'(busy), 32'h1);
    edge_n(1);
    chk("zero_done_e21", 32'(done), 32'h1);
    chk("zero_bcd_e21", 32'(bcdout), 32'h0);
    edge_n(1);
    chk("zero_done_e22", 32'(done), 32'h0);
    chk("zero_busy_e22", 32'(busy), 32'h0);

    // BIN=1023, START pulsed one cycle
    start = 1'b1; bin = 10'd1023; exp_q.push_back(to_bcd(1023));
    edge_n(1);
    start = 1'b0;
    edge_n(20);
    chk("max_bcd_e20_old", 32'(bcdout), 32'h0);
    edge_n(1);
    chk("max_bcd_e21", 32'(bcdout), 32'h1023);
    chk("max_done_e21", 32'(done), 32'h1);
    edge_n(1);
    chk("max_done_e22", 32'(done), 32'h0);
    edge_n(5);
    chk("max_bcd_hold", 32'(bcdout), 32'h1023);
    chk("max_busy_idle", 32'(busy), 32'h0);

    // START held, BIN changes mid-conversion
    start = 1'b1; bin = 10'd512; exp_q.push_back(to_bcd(512));
    edge_n(1);
    edge_n(5);
    bin = 10'd999;
    edge_n(16);
    chk("held_first_bcd", 32'(bcdout), 32'h0512);
    chk("held_first_done", 32'(done), 32'h1);
    exp_q.push_back(to_bcd(999));
    edge_n(1);
    start = 1'b0;
    chk("held_second_busy", 32'(busy), 32'h1);
    edge_n(20);
    chk("held_second_bcd_e42", 32'(bcdout), 32'h0512);
    edge_n(1);
    chk("held_second_bcd", 32'(bcdout), 32'h0999);
    chk("held_second_done", 32'(done), 32'h1);
    edge_n(1);

    // Reset mid-conversion with a prior result of 512
    start = 1'b1; bin = 10'd512; exp_q.push_back(to_bcd(512));
    edge_n(1);
    start = 1'b0;
    edge_n(22);
    chk("pre_abort_bcd", 32'(bcdout), 32'h0512);
    start = 1'b1; bin = 10'd777;
    edge_n(1);
    start = 1'b0;
    edge_n(10);
    rst = 1'b1;
    #1;
    chk("abort_bcd", 32'(bcdout), 32'h0);
    chk("abort_done", 32'(done), 32'h0);
    chk("abort_busy", 32'(busy), 32'h0);
    #1 rst = 1'b0;
    start = 1'b1; bin = 10'd777; exp_q.push_back(to_bcd(777));
    edge_n(1);
    start = 1'b0;
    edge_n(21);
    chk("post_abort_bcd", 32'(bcdout), 32'h0777);
    chk("post_abort_done", 32'(done), 32'h1);
    edge_n(1);

    // START dropped at edge 3 of a conversion
    start = 1'b1; bin = 10'd45; exp_q.push_back(to_bcd(45));
    edge_n(1);
    edge_n(3);
    start = 1'b0;
    edge_n(18);
    chk("drop_bcd", 32'(bcdout), 32'h0045);
    chk("drop_done", 32'(done), 32'h1);
    edge_n(1);
    d0 = done_cnt;
    edge_n(30);
    chk("drop_no_more_done", 32'(done_cnt - d0), 32'h0);
    chk("drop_idle_busy", 32'(busy), 32'h0);

    // Full sweep with START held
    d0 = done_cnt;
    start = 1'b1;
    for (int i = 0; i < 1024; i++) begin
      bin = 10'(i);
      exp_q.push_back(to_bcd(i));
      edge_n(1);
      if (i == 1023) start = 1'b0;
      edge_n(21);
    end
    edge_n(2);
    chk("sweep_done_count", 32'(done_cnt - d0), 32'd1024);
    chk("queue_drained", 32'(exp_q.size()), 32'h0);

    $display("test done: total=%0d bad=%0d", n_total, n_bad);
    $finish;
  end

endmodule
